// File: rtl/spi_master_xfer_seq.sv
// Transfer sequencer for an SPI master. It frames each transfer with CS setup and hold,
// runs the write and read byte handshakes with the shift engine, and repeats after a delay.
module spi_master_xfer_seq (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sys_xfer_start,
  input  logic [15:0] sys_xfer_count,
  input  logic [15:0] sys_xfer_delay,
  input  logic [15:0] sys_cs_count,
  input  logic [15:0] sys_wr_byte_count,
  input  logic [15:0] sys_rd_byte_count,
  input  logic [15:0] sys_rd_delay_count,
  output logic        byte_req,
  output logic        byte_wr,
  input  logic        byte_ack,
  output logic        wb_rd_en,
  output logic        rb_wr_en,
  output logic        cs_active,
  output logic        p_xfer_status,
  output logic        xfer_done
);
  typedef enum logic [2:0] {IDLE, CS_SETUP, WR, GAP, RD, CS_HOLD, DELAY} state_e;

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d, delay_q, delay_d, cs_q, cs_d;
  logic [15:0] wr_q, wr_d, rd_q, rd_d, rd_dly_q, rd_dly_d;
  logic [15:0] cyc_q, cyc_d, byte_q, byte_d;
  logic        req_q, req_d, wb_q, wb_d, rb_q, rb_d;
  logic        busy_q, busy_d, done_q, done_d, abort_q, abort_d;
  logic        launch, timer_done, ack_hit, last_byte, end_seq, in_byte_phase;
  logic [15:0] timer_len, byte_limit;

  assign launch        = (state_q == IDLE) && sys_xfer_start && !start_q;
  assign in_byte_phase = (state_q == WR) || (state_q == RD);
  assign byte_limit    = (state_q == WR) ? wr_q : rd_q;
  assign ack_hit       = in_byte_phase && req_q && byte_ack;
  assign last_byte     = ack_hit && ((byte_q + 16'd1) == byte_limit);
  assign end_seq       = (xfer_cnt_q == 16'd1) || abort_q || !sys_xfer_start;

  always_comb begin
    case (state_q)
      CS_SETUP, CS_HOLD: timer_len = cs_q;
      GAP:               timer_len = rd_dly_q;
      DELAY:             timer_len = delay_q;
      default:           timer_len = 16'd0;
    endcase
  end

  // A count of 0 behaves like 1: the compare already passes on the first cycle.
  assign timer_done = ({1'b0, cyc_q} + 17'd1) >= {1'b0, timer_len};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (launch && (sys_xfer_count != 16'd0)) state_d = CS_SETUP;
      CS_SETUP: if (timer_done) state_d = (wr_q != 16'd0) ? WR :
                                          (rd_q != 16'd0) ? GAP : CS_HOLD;
      WR:       if (last_byte) state_d = (rd_q != 16'd0) ? GAP : CS_HOLD;
      GAP:      if (timer_done) state_d = RD;
      RD:       if (last_byte) state_d = CS_HOLD;
      CS_HOLD:  if (timer_done) state_d = end_seq ? IDLE : DELAY;
      DELAY:    if (timer_done) state_d = CS_SETUP;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d    = sys_xfer_start;
    xfer_cnt_d = xfer_cnt_q;
    delay_d    = delay_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rd_dly_d   = rd_dly_q;
    busy_d     = busy_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    wb_d       = 1'b0;
    rb_d       = 1'b0;
    req_d      = req_q;
    byte_d     = byte_q;
    cyc_d      = (state_d != state_q || state_q == IDLE) ? 16'd0 : cyc_q + 16'd1;

    if (launch) begin
      xfer_cnt_d = sys_xfer_count;
      delay_d    = sys_xfer_delay;
      cs_d       = sys_cs_count;
      wr_d       = sys_wr_byte_count;
      rd_d       = sys_rd_byte_count;
      rd_dly_d   = sys_rd_delay_count;
      abort_d    = 1'b0;
      if (sys_xfer_count == 16'd0) done_d = 1'b1;
      else                         busy_d = 1'b1;
    end

    if (busy_q && !sys_xfer_start) abort_d = 1'b1;

    // After each ack, byte_req stays low for one cycle before the next byte is requested.
    if (in_byte_phase) begin
      if (ack_hit) begin
        req_d  = 1'b0;
        byte_d = byte_q + 16'd1;
        if (state_q == RD) rb_d = 1'b1;
      end else if (!req_q && (byte_q != byte_limit)) begin
        req_d = 1'b1;
        if (state_q == WR) wb_d = 1'b1;
      end
    end
    if (state_d != state_q) byte_d = 16'd0;

    if ((state_q == CS_HOLD) && timer_done) begin
      xfer_cnt_d = xfer_cnt_q - 16'd1;
      if (end_seq) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      start_q    <= 1'b0;
      xfer_cnt_q <= 16'd0;
      delay_q    <= 16'd0;
      cs_q       <= 16'd0;
      wr_q       <= 16'd0;
      rd_q       <= 16'd0;
      rd_dly_q   <= 16'd0;
      cyc_q      <= 16'd0;
      byte_q     <= 16'd0;
      req_q      <= 1'b0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      start_q    <= start_d;
      xfer_cnt_q <= xfer_cnt_d;
      delay_q    <= delay_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rd_dly_q   <= rd_dly_d;
      cyc_q      <= cyc_d;
      byte_q     <= byte_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    cs_active     = (state_q != IDLE) && (state_q != DELAY);
    byte_req      = req_q;
    byte_wr       = req_q && (state_q == WR);
    wb_rd_en      = wb_q;
    rb_wr_en      = rb_q;
    p_xfer_status = busy_q;
    xfer_done     = done_q;
  end
endmodule

// File: tb/tb_spi_master_xfer_seq.sv
// Self-checking bench for spi_master_xfer_seq: an ack responder, a negedge monitor and a
// window-length model derived from the sequence rules.
module tb_spi_master_xfer_seq;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0, sys_xfer_start = 1'b0, byte_ack = 1'b0;
  logic [15:0] sys_xfer_count = '0, sys_xfer_delay = '0, sys_cs_count = '0;
  logic [15:0] sys_wr_byte_count = '0, sys_rd_byte_count = '0, sys_rd_delay_count = '0;
  logic        byte_req, byte_wr, wb_rd_en, rb_wr_en, cs_active, p_xfer_status, xfer_done;
  int checks = 0, errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_master_xfer_seq dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_xfer_start(sys_xfer_start),
    .sys_xfer_count(sys_xfer_count), .sys_xfer_delay(sys_xfer_delay),
    .sys_cs_count(sys_cs_count), .sys_wr_byte_count(sys_wr_byte_count),
    .sys_rd_byte_count(sys_rd_byte_count), .sys_rd_delay_count(sys_rd_delay_count),
    .byte_req(byte_req), .byte_wr(byte_wr), .byte_ack(byte_ack),
    .wb_rd_en(wb_rd_en), .rb_wr_en(rb_wr_en), .cs_active(cs_active),
    .p_xfer_status(p_xfer_status), .xfer_done(xfer_done));

  // Shift-engine model: ack is sampled on the ack_dly-th edge after byte_req rises.
  int ack_dly = 1, ack_cnt = 0;
  bit spur_en = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    if (!byte_req) begin
      ack_cnt  = 0;
      byte_ack = spur_en && ($urandom_range(0, 2) == 0);
    end else begin
      ack_cnt++;
      if (ack_cnt == ack_dly) begin byte_ack = 1'b1; ack_cnt = 0; end
      else byte_ack = 1'b0;
    end
  end

  int cur_len, gap_len, wb_n, rb_n, done_n, busy_n, wreq_n, rreq_n, proto_n, rise_n;
  int win_q[$];
  int gap_q[$];
  logic cs_prev = 1'b0, req_prev = 1'b0, wr_prev = 1'b0, rdack_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (cs_active && !cs_prev) begin
      rise_n++;
      if (gap_len > 0) gap_q.push_back(gap_len);
      gap_len = 0;
    end
    if (cs_active) cur_len++;
    else begin
      if (cs_prev) begin win_q.push_back(cur_len); cur_len = 0; end
      if (p_xfer_status) gap_len++;
    end
    wb_n   += int'(wb_rd_en);
    rb_n   += int'(rb_wr_en);
    done_n += int'(xfer_done);
    busy_n += int'(p_xfer_status);
    if (byte_req && !req_prev) begin
      if (byte_wr) wreq_n++; else rreq_n++;
    end
    if (wb_rd_en && !(byte_req && !req_prev && byte_wr)) proto_n++;
    if (byte_req && req_prev && (byte_wr != wr_prev)) proto_n++;
    if ((byte_req || wb_rd_en || rb_wr_en) && !cs_active) proto_n++;
    if (rb_wr_en != rdack_prev) proto_n++;
    cs_prev    = cs_active;
    req_prev   = byte_req;
    wr_prev    = byte_wr;
    rdack_prev = byte_req && byte_ack && !byte_wr;
  end

  task automatic mon_clear();
    cur_len = 0; gap_len = 0; wb_n = 0; rb_n = 0; done_n = 0; busy_n = 0;
    wreq_n = 0; rreq_n = 0; proto_n = 0; rise_n = 0;
    win_q.delete(); gap_q.delete();
  endtask

  function automatic int m1(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  // One CS window: setup, write bytes, optional gap plus read bytes, hold.
  function automatic int win_len(input int cs, wr, rd, rdd, d);
    return 2 * m1(cs) + wr * (d + 1) + ((rd != 0) ? m1(rdd) + rd * (d + 1) : 0);
  endfunction

  function automatic int bad_wins(input int exp_len);
    int b = 0;
    foreach (win_q[i]) if (win_q[i] != exp_len) b++;
    return b;
  endfunction

  function automatic int bad_gaps(input int exp_len);
    int b = 0;
    foreach (gap_q[i]) if (gap_q[i] != exp_len) b++;
    return b;
  endfunction

  task automatic tick();
    @(posedge sys_clk); #2;
  endtask

  task automatic run_seq(input int cnt, dly, cs, wr, rd, rdd, d, abort_at,
                         output int lat, output bit tmo);
    bit dropped;
    dropped = 1'b0;
    sys_xfer_count = 16'(cnt); sys_xfer_delay = 16'(dly); sys_cs_count = 16'(cs);
    sys_wr_byte_count = 16'(wr); sys_rd_byte_count = 16'(rd); sys_rd_delay_count = 16'(rdd);
    ack_dly = d;
    sys_xfer_start = 1'b0;
    tick(); tick();
    mon_clear();
    sys_xfer_start = 1'b1;
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick(); lat++;
      if (i == 3) begin
        sys_xfer_count = 16'($urandom); sys_cs_count = 16'($urandom);
        sys_wr_byte_count = 16'($urandom); sys_rd_byte_count = 16'($urandom);
        sys_xfer_delay = 16'($urandom); sys_rd_delay_count = 16'($urandom);
      end
      if (abort_at != 0 && !dropped && rise_n >= abort_at) begin
        sys_xfer_start = 1'b0; dropped = 1'b1;
      end
      if (xfer_done || done_n > 0) begin tmo = 1'b0; break; end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    repeat (3) tick();
    outs = {cs_active, byte_req, byte_wr, wb_rd_en, rb_wr_en, p_xfer_status, xfer_done};
    checks++; if (outs !== 7'd0) begin errors++; $display("FAIL reset_outputs got %b expected 0000000", outs); end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, l; bit tmo;
    l = win_len(2, 2, 1, 3, 4);
    run_seq(1, 0, 2, 2, 1, 3, 4, 0, lat, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0d expected 0", tmo); end
    checks++; if (win_q.size() != 1 || bad_wins(l) != 0) begin errors++; $display("FAIL basic_cs_window got n=%0d len=%0d expected n=1 len=%0d", win_q.size(), (win_q.size() > 0) ? win_q[0] : -1, l); end
    checks++; if (wb_n != 2 || rb_n != 1) begin errors++; $display("FAIL basic_buf got wb=%0d rb=%0d expected wb=2 rb=1", wb_n, rb_n); end
    checks++; if (wreq_n != 2 || rreq_n != 1) begin errors++; $display("FAIL basic_reqs got wr=%0d rd=%0d expected 2 1", wreq_n, rreq_n); end
    checks++; if (done_n != 1 || busy_n != l) begin errors++; $display("FAIL basic_done_busy got done=%0d busy=%0d expected 1 %0d", done_n, busy_n, l); end
    checks++; if (proto_n != 0) begin errors++; $display("FAIL basic_protocol got %0d violations expected 0", proto_n); end
    $display("basic: window=%0d wb=%0d rb=%0d done=%0d", l, wb_n, rb_n, done_n);
  endtask

  task automatic test_repeat_delay();
    int lat, l, cs, d; bit tmo;
    cs = $urandom_range(0, 3); d = $urandom_range(1, 4);
    l = win_len(cs, 1, 0, 0, d);
    run_seq(3, 5, cs, 1, 0, 7, d, 0, lat, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL repeat_timeout got %0d expected 0", tmo); end
    checks++; if (win_q.size() != 3 || bad_wins(l) != 0) begin errors++; $display("FAIL repeat_windows got n=%0d bad=%0d expected n=3 len=%0d", win_q.size(), bad_wins(l), l); end
    checks++; if (gap_q.size() != 2 || bad_gaps(5) != 0) begin errors++; $display("FAIL repeat_gaps got n=%0d bad=%0d expected n=2 len=5", gap_q.size(), bad_gaps(5)); end
    checks++; if (wb_n != 3 || rreq_n != 0 || rb_n != 0) begin errors++; $display("FAIL repeat_bytes got wb=%0d rreq=%0d rb=%0d expected 3 0 0", wb_n, rreq_n, rb_n); end
    checks++; if (done_n != 1 || busy_n != 3 * l + 10) begin errors++; $display("FAIL repeat_done_busy got done=%0d busy=%0d expected 1 %0d", done_n, busy_n, 3 * l + 10); end
    $display("repeat_delay: cs=%0d ack=%0d windows=%0d gaps=%0d", cs, d, win_q.size(), gap_q.size());
  endtask

  task automatic test_zero_count();
    int lat; bit tmo;
    run_seq(0, 3, 3, 2, 2, 2, 2, 0, lat, tmo);
    checks++; if (tmo !== 1'b0 || lat != 1) begin errors++; $display("FAIL zero_count_latency got %0d expected 1", lat); end
    checks++; if (rise_n != 0 || busy_n != 0 || done_n != 1) begin errors++; $display("FAIL zero_count_outputs got cs=%0d busy=%0d done=%0d expected 0 0 1", rise_n, busy_n, done_n); end
    $display("zero_count: done latency=%0d", lat);
  endtask

  task automatic test_zero_bytes();
    int lat; bit tmo;
    run_seq(1, 0, 0, 0, 0, 4, 2, 0, lat, tmo);
    checks++; if (tmo !== 1'b0 || win_q.size() != 1 || bad_wins(2) != 0) begin errors++; $display("FAIL zero_bytes_window got n=%0d len=%0d expected n=1 len=2", win_q.size(), (win_q.size() > 0) ? win_q[0] : -1); end
    checks++; if (wreq_n + rreq_n + wb_n + rb_n != 0) begin errors++; $display("FAIL zero_bytes_reqs got %0d expected 0", wreq_n + rreq_n + wb_n + rb_n); end
    $display("zero_bytes: window=%0d", (win_q.size() > 0) ? win_q[0] : -1);
  endtask

  task automatic test_random();
    int lat, l, cnt, dly, cs, wr, rd, rdd, d; bit tmo;
    spur_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cnt = $urandom_range(1, 3); dly = $urandom_range(0, 4); cs = $urandom_range(0, 3);
      wr = $urandom_range(0, 3); rd = $urandom_range(0, 3); rdd = $urandom_range(0, 3);
      d = $urandom_range(1, 3);
      l = win_len(cs, wr, rd, rdd, d);
      run_seq(cnt, dly, cs, wr, rd, rdd, d, 0, lat, tmo);
      checks++; if (tmo !== 1'b0 || win_q.size() != cnt || bad_wins(l) != 0) begin errors++; $display("FAIL random%0d_windows got n=%0d bad=%0d expected n=%0d len=%0d", k, win_q.size(), bad_wins(l), cnt, l); end
      checks++; if (gap_q.size() != cnt - 1 || bad_gaps(m1(dly)) != 0) begin errors++; $display("FAIL random%0d_gaps got n=%0d bad=%0d expected n=%0d len=%0d", k, gap_q.size(), bad_gaps(m1(dly)), cnt - 1, m1(dly)); end
      checks++; if (wb_n != cnt * wr || rb_n != cnt * rd || rreq_n != cnt * rd) begin errors++; $display("FAIL random%0d_bytes got wb=%0d rb=%0d expected %0d %0d", k, wb_n, rb_n, cnt * wr, cnt * rd); end
      checks++; if (done_n != 1 || busy_n != cnt * l + (cnt - 1) * m1(dly) || proto_n != 0) begin errors++; $display("FAIL random%0d_done_busy got done=%0d busy=%0d proto=%0d expected 1 %0d 0", k, done_n, busy_n, proto_n, cnt * l + (cnt - 1) * m1(dly)); end
      $display("random%0d: cnt=%0d dly=%0d cs=%0d wr=%0d rd=%0d rdd=%0d ack=%0d window=%0d", k, cnt, dly, cs, wr, rd, rdd, d, l);
    end
  endtask

  task automatic test_abort();
    int lat, l; bit tmo;
    l = win_len(1, 2, 1, 2, 2);
    run_seq(4, 3, 1, 2, 1, 2, 2, 2, lat, tmo);
    checks++; if (tmo !== 1'b0 || win_q.size() != 2 || bad_wins(l) != 0) begin errors++; $display("FAIL abort_windows got n=%0d bad=%0d expected n=2 len=%0d", win_q.size(), bad_wins(l), l); end
    checks++; if (wb_n != 4 || rb_n != 2 || done_n != 1 || busy_n != 2 * l + 3) begin errors++; $display("FAIL abort_counts got wb=%0d rb=%0d done=%0d busy=%0d expected 4 2 1 %0d", wb_n, rb_n, done_n, busy_n, 2 * l + 3); end
    repeat (20) tick();
    checks++; if (rise_n != 2 || done_n != 1) begin errors++; $display("FAIL abort_no_restart got cs_windows=%0d done=%0d expected 2 1", rise_n, done_n); end
    $display("abort: windows=%0d done=%0d", rise_n, done_n);
  endtask

  task automatic test_reset_mid_rd();
    int l, dn; bit seen, fin; logic [6:0] outs;
    seen = 1'b0; fin = 1'b0;
    l = win_len(1, 1, 3, 1, 3);
    sys_xfer_count = 16'd2; sys_xfer_delay = 16'd2; sys_cs_count = 16'd1;
    sys_wr_byte_count = 16'd1; sys_rd_byte_count = 16'd3; sys_rd_delay_count = 16'd1;
    ack_dly = 3; sys_xfer_start = 1'b0;
    tick(); tick();
    mon_clear();
    sys_xfer_start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (byte_req && !byte_wr) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_rd_reach got %0d expected 1", seen); end
    dn = done_n;
    #2 sys_rst_n = 1'b0;
    #1 outs = {cs_active, byte_req, byte_wr, wb_rd_en, rb_wr_en, p_xfer_status, xfer_done};
    checks++; if (outs !== 7'd0) begin errors++; $display("FAIL rst_mid_rd_async got %b expected 0000000", outs); end
    tick(); tick();
    checks++; if (done_n != dn) begin errors++; $display("FAIL rst_mid_rd_no_done got %0d expected %0d", done_n, dn); end
    mon_clear();
    #2 sys_rst_n = 1'b1;
    tick();
    checks++; if (cs_active !== 1'b1 || p_xfer_status !== 1'b1) begin errors++; $display("FAIL rst_relaunch got cs=%b busy=%b expected 1 1", cs_active, p_xfer_status); end
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done_n > 0) begin fin = 1'b1; break; end
    end
    repeat (3) tick();
    checks++; if (!fin || win_q.size() != 2 || bad_wins(l) != 0 || rb_n != 6) begin errors++; $display("FAIL rst_relaunch_seq got done=%0d n=%0d bad=%0d rb=%0d expected 1 2 0 6", fin, win_q.size(), bad_wins(l), rb_n); end
    $display("reset_mid_rd: relaunched windows=%0d rb=%0d", win_q.size(), rb_n);
  endtask

  task automatic test_held_start();
    int lat, viol; bit tmo;
    run_seq(1, 0, 1, 1, 0, 0, 1, 0, lat, tmo);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cs_active || p_xfer_status || xfer_done) viol++;
    end
    checks++; if (tmo !== 1'b0 || viol != 0 || rise_n != 1 || sys_xfer_start !== 1'b1) begin errors++; $display("FAIL held_start got viol=%0d cs_windows=%0d expected 0 1", viol, rise_n); end
    $display("held_start: idle cycles with violations=%0d", viol);
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_basic();
    test_repeat_delay();
    test_zero_count();
    test_zero_bytes();
    test_random();
    test_abort();
    test_reset_mid_rd();
    test_held_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
